// File: rtl/lv_abist_seq.sv
// Analog BIST sequencer: steps through the enabled items in ascending order.
// Each item gets a response window, and a settle gap follows every item.
module lv_abist_seq #(
  parameter int CLK_M    = 48,
  parameter int ITEM_NUM = 4,
  parameter int WIN_US   = 70,
  parameter int GAP_US   = 10
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_bist_start,
  input  logic                i_bist_abort,
  input  logic [ITEM_NUM-1:0] i_item_mask,
  input  logic [ITEM_NUM-1:0] i_abist_flag,
  output logic [ITEM_NUM-1:0] o_bist_en,
  output logic                o_bist_busy,
  output logic                o_bist_done,
  output logic [ITEM_NUM-1:0] o_bist_status,
  output logic                o_bist_fail
);

  localparam int WIN_CYC = WIN_US * CLK_M;
  localparam int GAP_CYC = GAP_US * CLK_M;
  localparam int MAX_CYC = (WIN_CYC > GAP_CYC) ? WIN_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (ITEM_NUM > 1) ? $clog2(ITEM_NUM) : 1;

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ITEM_NUM-1:0] mask_q, mask_d;
  logic [ITEM_NUM-1:0] en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ITEM_NUM-1:0] status_q, status_d;
  logic                fail_q, fail_d;

  logic [IDX_W:0]      first_item;
  logic [IDX_W:0]      next_item;
  logic [CNT_W-1:0]    cnt_inc;

  // Lowest set bit at or above position 'from'; MSB of the result flags a hit.
  function automatic logic [IDX_W:0] find_from(input logic [ITEM_NUM-1:0] mask,
                                               input int from);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = ITEM_NUM - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

  function automatic logic [ITEM_NUM-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [ITEM_NUM-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  assign first_item = find_from(i_item_mask, 0);
  assign next_item  = find_from(mask_q, int'(idx_q) + 1);
  assign cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    en_d     = en_q;
    done_d   = 1'b0;
    status_d = status_q;
    fail_d   = fail_q;

    case (state_q)
      S_IDLE: begin
        if (i_bist_start) begin
          mask_d   = i_item_mask;
          status_d = '0;
          cnt_d    = '0;
          if (first_item[IDX_W]) begin
            state_d = S_ACTIVE;
            idx_d   = first_item[IDX_W-1:0];
            en_d    = onehot(first_item[IDX_W-1:0]);
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            fail_d  = 1'b0;
          end
        end
      end
      S_ACTIVE: begin
        cnt_d = cnt_inc;
        if (i_abist_flag[idx_q] && (cnt_q <= WIN_LAST)) begin
          status_d[idx_q] = 1'b1;
          en_d            = '0;
          cnt_d           = '0;
          state_d         = S_GAP;
        end else if (cnt_q == WIN_LAST) begin
          en_d    = '0;
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_inc;
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (next_item[IDX_W]) begin
            state_d = S_ACTIVE;
            idx_d   = next_item[IDX_W-1:0];
            en_d    = onehot(next_item[IDX_W-1:0]);
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            fail_d  = |(mask_q & ~status_q);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides any pass, timeout or completion decided above.
    if (i_bist_abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      en_d     = '0;
      done_d   = 1'b0;
      status_d = status_q;
      fail_d   = fail_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      mask_q   <= '0;
      en_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= '0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      status_q <= status_d;
      fail_q   <= fail_d;
    end
  end

  assign o_bist_en     = en_q;
  assign o_bist_busy   = busy_q;
  assign o_bist_done   = done_q;
  assign o_bist_status = status_q;
  assign o_bist_fail   = fail_q;

endmodule

// File: tb/tb_lv_abist_seq.sv
// Randomized bench for lv_abist_seq; expected timing and results are derived
// from per-item window/gap arithmetic rather than a cycle-level replica.
module tb_lv_abist_seq;

  localparam int WIN = 3360;
  localparam int GAP = 480;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_bist_start;
  logic       i_bist_abort;
  logic [3:0] i_item_mask;
  logic [3:0] i_abist_flag;
  logic [3:0] o_bist_en;
  logic       o_bist_busy;
  logic       o_bist_done;
  logic [3:0] o_bist_status;
  logic       o_bist_fail;

  int n_chk = 0;
  int n_err = 0;
  logic g_fail = 1'b0;

  lv_abist_seq #(
    .CLK_M(48), .ITEM_NUM(4), .WIN_US(70), .GAP_US(10)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_bist_start (i_bist_start),
    .i_bist_abort (i_bist_abort),
    .i_item_mask  (i_item_mask),
    .i_abist_flag (i_abist_flag),
    .o_bist_en    (o_bist_en),
    .o_bist_busy  (o_bist_busy),
    .o_bist_done  (o_bist_done),
    .o_bist_status(o_bist_status),
    .o_bist_fail  (o_bist_fail)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sequence run. fN = ACTIVE-relative cycle at which flag N is raised.
  // ab_item >= 0 requests an abort ab_off cycles into that item's window.
  task automatic run_seq(input logic [3:0] mask, input int f0, input int f1,
                         input int f2, input int f3, input bit noise,
                         input int ab_item, input int ab_off);
    int fa[4];
    int st_e[4], len_e[4], st_o[4], len_o[4];
    logic [3:0] st_exp, st_ab, status_o, en_prev, fl;
    logic fail_e, fail_o;
    int tt, done_e, done_o, ab_t, t_end;
    int viol_oh, viol_busy, unsel_cnt, done_after;

    fa = '{f0, f1, f2, f3};
    tt = 1;
    st_exp = '0;
    for (int k = 0; k < 4; k++) begin
      st_e[k] = -1; len_e[k] = 0; st_o[k] = -1; len_o[k] = 0;
      if (mask[k]) begin
        st_e[k]  = tt;
        len_e[k] = (fa[k] < WIN) ? fa[k] + 1 : WIN;
        if (fa[k] < WIN) st_exp[k] = 1'b1;
        tt += len_e[k] + GAP;
      end
    end
    done_e = tt;
    fail_e = |(mask & ~st_exp);
    ab_t   = (ab_item >= 0) ? st_e[ab_item] + ab_off : -1;
    st_ab  = '0;
    for (int k = 0; k < 4; k++)
      if (mask[k] && fa[k] < WIN && st_e[k] + fa[k] < ab_t) st_ab[k] = 1'b1;
    t_end = (ab_t > 0) ? ab_t + 20 : done_e + 40;

    viol_oh = 0; viol_busy = 0; unsel_cnt = 0; done_after = 0;
    done_o = -1; status_o = '0; fail_o = 1'b0; en_prev = '0;

    @(negedge clk);
    i_item_mask  = mask;
    i_bist_start = 1'b1;
    i_bist_abort = 1'b0;
    i_abist_flag = '0;

    for (int t = 1; t <= t_end; t++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (o_bist_en[k] && !en_prev[k]) st_o[k] = t;
        if (o_bist_en[k]) len_o[k]++;
        if (o_bist_en[k] && !mask[k]) unsel_cnt++;
      end
      if ($countones(o_bist_en) > 1) viol_oh++;
      en_prev = o_bist_en;

      if (ab_t > 0 && t == ab_t + 1) begin
        check_val("abort_en", o_bist_en, 0);
        check_val("abort_busy", o_bist_busy, 0);
        check_val("abort_done", o_bist_done, 0);
        check_val("abort_status", o_bist_status, st_ab);
        check_val("abort_fail", o_bist_fail, g_fail);
      end else if (ab_t > 0 && t > ab_t + 1) begin
        if (o_bist_done) done_after++;
      end else if (done_o < 0) begin
        if (o_bist_done) begin
          done_o = t; status_o = o_bist_status; fail_o = o_bist_fail;
          check_val("done_busy", o_bist_busy, 1);
        end else if (!o_bist_busy) viol_busy++;
      end else if (t == done_o + 1) begin
        check_val("post_done_busy", o_bist_busy, 0);
        check_val("post_done_pulse", o_bist_done, 0);
        break;
      end

      i_bist_start = (t == 2 && done_e > 3);
      i_item_mask  = 4'($urandom_range(0, 15));
      i_bist_abort = (t == ab_t);
      for (int k = 0; k < 4; k++) begin
        if (st_o[k] > 0 && t - st_o[k] == fa[k]) fl[k] = 1'b1;
        else if (noise && !o_bist_en[k]) fl[k] = 1'($urandom_range(0, 1));
        else fl[k] = 1'b0;
      end
      i_abist_flag = fl;
    end

    i_bist_start = 1'b0;
    i_bist_abort = 1'b0;
    i_abist_flag = '0;

    check_val("onehot_viol", viol_oh, 0);
    check_val("unsel_en", unsel_cnt, 0);
    if (ab_t > 0) begin
      check_val("done_after_abort", done_after, 0);
      check_val("done_before_abort", done_o, -1);
    end else begin
      check_val("busy_viol", viol_busy, 0);
      check_val("done_time", done_o, done_e);
      check_val("status", status_o, st_exp);
      check_val("fail", fail_o, fail_e);
      for (int k = 0; k < 4; k++) begin
        if (mask[k]) begin
          check_val($sformatf("en%0d_start", k), st_o[k], st_e[k]);
          check_val($sformatf("en%0d_len", k), len_o[k], len_e[k]);
        end
      end
      g_fail = fail_e;
      repeat (5) @(negedge clk);
      check_val("hold_status", o_bist_status, st_exp);
      check_val("hold_fail", o_bist_fail, fail_e);
    end
  endtask

  task automatic reset_in_gap();
    int done_cnt, busy_cnt;
    @(negedge clk);
    i_item_mask  = 4'b0001;
    i_bist_start = 1'b1;
    i_abist_flag = 4'b1111;
    @(negedge clk);
    i_bist_start = 1'b0;
    repeat (5) @(negedge clk);
    check_val("gap_en", o_bist_en, 0);
    check_val("gap_busy", o_bist_busy, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check_val("rst_en", o_bist_en, 0);
    check_val("rst_busy", o_bist_busy, 0);
    check_val("rst_done", o_bist_done, 0);
    check_val("rst_status", o_bist_status, 0);
    check_val("rst_fail", o_bist_fail, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    i_abist_flag = '0;
    done_cnt = 0; busy_cnt = 0;
    repeat (600) begin
      @(negedge clk);
      if (o_bist_done) done_cnt++;
      if (o_bist_busy) busy_cnt++;
    end
    check_val("rst_no_done", done_cnt, 0);
    check_val("rst_idle", busy_cnt, 0);
    g_fail = 1'b0;
  endtask

  initial begin
    int fr[4];
    i_rst_n      = 1'b0;
    i_bist_start = 1'b0;
    i_bist_abort = 1'b0;
    i_item_mask  = '0;
    i_abist_flag = '0;
    repeat (3) @(negedge clk);
    check_val("reset_en", o_bist_en, 0);
    check_val("reset_busy", o_bist_busy, 0);
    check_val("reset_done", o_bist_done, 0);
    check_val("reset_status", o_bist_status, 0);
    check_val("reset_fail", o_bist_fail, 0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_seq(4'b0001, 100, 0, 0, 0, 1'b0, -1, 0);
    run_seq(4'b0010, 0, 99999, 0, 0, 1'b0, -1, 0);
    run_seq(4'b1010, 0, 50, 0, 200, 1'b1, -1, 0);
    run_seq(4'b0110, 0, WIN - 1, WIN, 0, 1'b1, -1, 0);
    run_seq(4'b1111, 10, 10, 10, 10, 1'b0, 3, 5);
    run_seq(4'b0000, 0, 0, 0, 0, 1'b0, -1, 0);
    reset_in_gap();
    run_seq(4'b0011, 20, WIN, 0, 0, 1'b1, -1, 0);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 7))
          0:       fr[k] = WIN - 1;
          1:       fr[k] = WIN;
          default: fr[k] = $urandom_range(0, 400);
        endcase
      end
      run_seq(4'($urandom_range(0, 15)), fr[0], fr[1], fr[2], fr[3],
              1'($urandom_range(0, 1)), -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lv_abist_seq.md
LV_ABIST_SEQ -- requirements
Module: lv_abist_seq

Interface
REQ-001 Parameter CLK_M, default 48, clock cycles per microsecond.
REQ-002 Parameter ITEM_NUM, default 4, number of analog BIST items (bit 0 lv_ov, 1 lv_uv, 2 vref_ov, 3 ot).
REQ-003 Parameter WIN_US, default 70, per-item response window in us; WIN_CYC = WIN_US*CLK_M.
REQ-004 Parameter GAP_US, default 10, inter-item settle gap in us; GAP_CYC = GAP_US*CLK_M.
REQ-005 i_clk  input  1  clock.
REQ-006 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_bist_start  input  1  single-cycle request to run the sequence.
REQ-008 i_bist_abort  input  1  abort the running sequence.
REQ-009 i_item_mask  input  ITEM_NUM  item enable mask.
REQ-010 i_abist_flag  input  ITEM_NUM  comparator flag per item; already synchronous to i_clk.
REQ-011 o_bist_en  output  ITEM_NUM  force/stimulus enable to the analog item, at most one bit high.
REQ-012 o_bist_busy  output  1  sequence in progress.
REQ-013 o_bist_done  output  1  one-cycle pulse at sequence completion.
REQ-014 o_bist_status  output  ITEM_NUM  per-item result: 1 pass, 0 fail or not run.
REQ-015 o_bist_fail  output  1  at least one masked item failed in the last completed run.

Function
REQ-016 The FSM SHALL have the states IDLE, ACTIVE, GAP and DONE, and all outputs SHALL be registered.
REQ-017 In IDLE, i_bist_start SHALL latch i_item_mask, clear o_bist_status, and go to ACTIVE on the lowest set mask bit; a latched mask of 0 SHALL go directly to DONE.
REQ-018 i_bist_start outside IDLE SHALL be ignored, and i_item_mask changes after the latch SHALL have no effect.
REQ-019 In ACTIVE, o_bist_en[idx] SHALL be 1 and the cycle counter SHALL start at 0 on entry and increment each cycle.
REQ-020 ACTIVE pass: if i_abist_flag[idx]==1 in any cycle with cnt<=WIN_CYC-1, the block SHALL set o_bist_status[idx]=1, deassert o_bist_en the next cycle, and enter GAP.
REQ-021 ACTIVE fail: if cnt==WIN_CYC-1 and no flag is seen, the block SHALL leave o_bist_status[idx]=0 and enter GAP, so o_bist_en is high for exactly WIN_CYC cycles.
REQ-022 Flags of non-selected items SHALL be ignored.
REQ-023 GAP SHALL hold o_bist_en=0 for exactly GAP_CYC cycles, then go to ACTIVE on the next higher set mask bit, or to DONE if there is none.
REQ-024 DONE SHALL last one cycle with o_bist_done=1, SHALL load o_bist_fail = |(mask & ~o_bist_status), and SHALL return to IDLE.
REQ-025 o_bist_busy SHALL be 1 in ACTIVE, GAP and DONE, and 0 in IDLE.
REQ-026 i_bist_abort in ACTIVE, GAP or DONE SHALL, on the next cycle, give IDLE, o_bist_en=0 and no o_bist_done, with o_bist_status keeping partial results and o_bist_fail unchanged.
REQ-027 Abort SHALL take priority over pass/fail and over the DONE pulse in the same cycle.
REQ-028 The counter width SHALL be $clog2(max(WIN_CYC,GAP_CYC)+1), and the counter SHALL saturate without wrap-around.
REQ-029 o_bist_status and o_bist_fail SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-030 While i_rst_n==0, all outputs, the counter, the index and the latched mask SHALL be 0 and the state SHALL be IDLE.
REQ-031 Reset mid-sequence SHALL drop o_bist_en immediately (asynchronously), and no o_bist_done SHALL follow.

Verification (CLK_M=48: WIN_CYC=3360, GAP_CYC=480)
REQ-032 mask=0001, flag[0] high at ACTIVE cnt 100 -> o_bist_en[0] high for 101 cycles, status=0001, done pulse after the 480-cycle gap, fail=0.
REQ-033 mask=0010, flag never set -> o_bist_en[1] high for exactly 3360 cycles, status=0000, fail=1.
REQ-034 mask=1010, items pass -> en[1] then en[3] with no overlap, gap of 480 cycles, en[0]/en[2] never asserted, status=1010, fail=0.
REQ-035 Flag at cnt 3359 -> pass; flag first at cnt 3360 -> fail; flag[2] asserted while item 1 is active -> ignored.
REQ-036 Abort during the item 3 ACTIVE of mask=1111 -> IDLE next cycle, en=0, no done, status keeps items 0-2, start during busy is ignored, and start with mask=0 gives a done pulse 1 cycle later with fail=0.
REQ-037 Reset asserted during GAP -> all outputs 0 and state IDLE, and a subsequent start runs normally.
